// File: rtl/ram_req_ctrl_if.sv
// Host request/response channel and RAM port bundle for ram_req_ctrl.
// slave = controller side, master = host/RAM side.
interface ram_req_ctrl_if #(
  parameter int DW = 4,
  parameter int AW = 2
);
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          ram_en;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready, ram_out,
    output req_ready, rsp_valid, rsp_data, ram_en, ram_rw, ram_addr, ram_in
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready, ram_out,
    input  req_ready, rsp_valid, rsp_data, ram_en, ram_rw, ram_addr, ram_in
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Single-outstanding request sequencer for the single-port RAM: write = 1 cycle,
// read = READ + RD_WAIT (holds enable over the capture edge) then RESP until rsp_ready.
module ram_req_ctrl #(
  parameter int DW = 4,
  parameter int AW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_req_ctrl_if.slave bus,
  output logic          busy,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] rd_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_rw_q, ram_rw_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_in_q, ram_in_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic [CW-1:0] rd_count_q, rd_count_d;

  // Gated by rst so the host sees no acceptance window while reset is held.
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_rw    = ram_rw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_in    = ram_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;

  always_comb begin
    state_d     = state_q;
    ram_en_d    = ram_en_q;
    ram_rw_d    = ram_rw_q;
    ram_addr_d  = ram_addr_q;
    ram_in_d    = ram_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d    = bus.req_rw ? WRITE : READ;
          ram_en_d   = 1'b1;
          ram_rw_d   = bus.req_rw;
          ram_addr_d = bus.req_addr;
          ram_in_d   = bus.req_wdata;
        end
      end
      WRITE: begin
        ram_en_d = 1'b0;
        if (wr_count_q != {CW{1'b1}}) wr_count_d = wr_count_q + CW'(1);
        state_d  = IDLE;
      end
      READ: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // RAM re-reads the same address this cycle, so ram_out is stable at capture.
        rsp_data_d  = bus.ram_out;
        rsp_valid_d = 1'b1;
        ram_en_d    = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rd_count_q != {CW{1'b1}}) rd_count_d = rd_count_q + CW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        ram_en_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_in_q    <= ram_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

endmodule
